hyst_comparator: RTL and testbench
==================================

// Module: hyst_comparator
// PURPOSE
//  Registered N-bit magnitude comparator with hysteresis band and persistence filter.
//  Compares measured speed (a) against set-point (b) for the cruise-control loop.
//  Emits debounced one-hot G/Eq/L decisions that do not chatter near the set-point.
// PARAMETERS
//  WIDTH  8  operand width, unsigned
//  BAND   2  tolerance: |a-b| <= BAND counts as equal; 0 <= BAND < 2**WIDTH
//  HOLD   4  consecutive valid samples needed to change a settled decision; HOLD >= 1
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  reset    in   1      asynchronous, active-high reset
//  enable   in   1      block enable; low forces outputs to 0 and clears decision
//  valid    in   1      a/b carry a new sample this cycle
//  a        in   WIDTH  measured value
//  b        in   WIDTH  reference value
//  G        out  1      a > b+BAND (settled), registered
//  Eq       out  1      |a-b| <= BAND (settled), registered
//  L        out  1      a < b-BAND (settled), registered
//  changed  out  1      one-cycle pulse when the G/Eq/L decision changes
// BEHAVIOUR
//  - Reset (async): state=S_IDLE, count=0, G=Eq=L=0, changed=0. Takes effect immediately, mid-count too.
//  - Raw class per sample: diff=|a-b| in WIDTH+1 bits (no wrap); diff<=BAND->EQ, a>b->GT, else LT.
//    diff==BAND exactly is EQ.
//  - States: S_IDLE, S_EQ, S_GT, S_LT. Outputs are one-hot decode of state (all 0 in S_IDLE).
//  - S_IDLE + enable + valid: go straight to raw class at next edge (latency 1), changed=1.
//  - Settled state + valid: raw==state -> count=0; raw!=state and raw==cand -> count+1;
//    raw!=cand -> cand=raw, count=1. When count reaches HOLD: state=cand, count=0, changed=1.
//    HOLD=1 => every differing sample switches after 1 cycle.
//  - valid low: state, cand, count held; changed=0.
//  - enable low (any state): next edge state=S_IDLE, count=0, outputs 0; changed=1 if leaving
//    a settled state. enable has priority over valid.
//  - changed is 0 in every cycle not listed above; it never stays high two cycles
//    unless the decision changes on consecutive edges.
// CONFIGURATION
//  - HYST_CMP_DIFF_EN defined: extra output port diff [WIDTH-1:0] = registered |a-b| of the last
//    accepted sample (enable & valid); reset value 0; unaffected by HOLD filtering.
//  - Undefined: diff port and its register absent; all other behaviour identical.
// STRUCTURE
//  - Shared package cruise_pkg: state encodings S_IDLE/S_EQ/S_GT/S_LT (2-bit) and raw-class
//    codes CLS_EQ/CLS_GT/CLS_LT, reused by the cruise-control FSM.
//  - One combinational sub-module band_classifier (a, b -> raw class, diff). Top holds FSM,
//    candidate register, count ($clog2(HOLD+1) bits) and output registers.
// TESTING (WIDTH=8, BAND=2, HOLD=4)
//  1. reset, enable=1, valid=1, a=50 b=50 -> next edge Eq=1, G=L=0, changed=1 for one cycle.
//  2. a=52 b=50 for 10 samples -> Eq stays 1, changed=0 (boundary diff==BAND).
//     then a=53 for 4 samples -> G=1 at the 4th sample edge, changed pulse.
//  3. from G: a=40 x3, a=60 x1, a=40 x3 -> G holds (count restarts); 4th consecutive a=40 -> L=1.
//     Insert valid=0 gaps between samples -> same result, count held across gaps.
//  4. a=255 b=0 -> G; a=0 b=255 -> L after 4 samples; a=255 b=254 -> Eq; no overflow artefacts.
//  5. enable=0 for one cycle while L -> all outputs 0 next edge, changed=1; enable=1,
//     a=10 b=40 -> L=1 after one edge (no HOLD from IDLE).
//  6. reset asserted mid-count (count=3) -> G/Eq/L/changed 0 without waiting for clk;
//     with HYST_CMP_DIFF_EN, diff=0 and a=70 b=50 accepted -> diff=20 next edge.

Source files
------------

// File: rtl/cruise_pkg.sv
// rtl/cruise_pkg.sv - shared state and raw-class encodings for the cruise-control comparator
package cruise_pkg;

   // Settled decision of the comparator; S_IDLE drives all outputs low
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EQ   = 2'd1,
      S_GT   = 2'd2,
      S_LT   = 2'd3
   } state_e;

   // Per-sample class; codes line up with the matching settled states
   typedef enum logic [1:0] {
      CLS_EQ = 2'd1,
      CLS_GT = 2'd2,
      CLS_LT = 2'd3
   } cls_e;

   // Settled state that a raw class maps onto
   function automatic state_e cls_to_state(input cls_e c);
      return state_e'(c);
   endfunction

endpackage

// File: rtl/band_classifier.sv
// rtl/band_classifier.sv - combinational |a-b| and raw GT/EQ/LT class against a tolerance band
// Optional: HYST_CMP_DIFF_EN exposes the magnitude difference on port diff.
module band_classifier
   import cruise_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BAND  = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cls_e             cls
`ifdef HYST_CMP_DIFF_EN
   ,
   output logic [WIDTH-1:0] diff
`endif
);

   localparam logic [WIDTH:0] BAND_C = (WIDTH+1)'(BAND);

   // One extra bit keeps the subtraction free of wrap-around at the range ends
   logic [WIDTH:0] w_diff;

   // Magnitude difference, then band test; diff == BAND counts as equal
   always_comb begin
      if (a > b) begin
         w_diff = {1'b0, a} - {1'b0, b};
      end else begin
         w_diff = {1'b0, b} - {1'b0, a};
      end
      if (w_diff <= BAND_C) begin
         cls = CLS_EQ;
      end else if (a > b) begin
         cls = CLS_GT;
      end else begin
         cls = CLS_LT;
      end
   end

`ifdef HYST_CMP_DIFF_EN
   // |a-b| never exceeds 2**WIDTH-1, so the top bit is always zero here
   assign diff = w_diff[WIDTH-1:0];
`endif

endmodule

// File: rtl/hyst_comparator.sv
// rtl/hyst_comparator.sv - registered magnitude comparator with hysteresis band and persistence filter
// Optional: HYST_CMP_DIFF_EN adds output diff, the registered |a-b| of the last accepted sample.
module hyst_comparator
   import cruise_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BAND  = 2,
   parameter int HOLD  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             G,
   output logic             Eq,
   output logic             L,
   output logic             changed
`ifdef HYST_CMP_DIFF_EN
   ,
   output logic [WIDTH-1:0] diff
`endif
);

   localparam int            CW     = $clog2(HOLD + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

   cls_e          w_cls;
   state_e        r_state, w_state_nx;
   cls_e          r_cand, w_cand_nx;
   logic [CW-1:0] r_count, w_count_nx;
   logic          w_changed_nx;
   logic          r_g, r_eq, r_l, r_changed;

`ifdef HYST_CMP_DIFF_EN
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] r_diff;
`endif

   band_classifier #(
      .WIDTH (WIDTH),
      .BAND  (BAND)
   ) u_band_classifier (
      .a    (a),
      .b    (b),
      .cls  (w_cls)
`ifdef HYST_CMP_DIFF_EN
      ,
      .diff (w_diff)
`endif
   );

   // Next decision: IDLE adopts the first sample, settled states need HOLD agreeing samples
   always_comb begin
      w_state_nx   = r_state;
      w_cand_nx    = r_cand;
      w_count_nx   = r_count;
      w_changed_nx = 1'b0;
      if (!enable) begin
         w_state_nx   = S_IDLE;
         w_count_nx   = '0;
         w_changed_nx = (r_state != S_IDLE);
      end else if (valid) begin
         if (r_state == S_IDLE) begin
            w_state_nx   = cls_to_state(w_cls);
            w_count_nx   = '0;
            w_changed_nx = 1'b1;
         end else begin
            if (cls_to_state(w_cls) == r_state) begin
               w_count_nx = '0;
            end else if (w_cls == r_cand) begin
               w_count_nx = r_count + CW'(1);
            end else begin
               w_cand_nx  = w_cls;
               w_count_nx = CW'(1);
            end
            if (w_count_nx == HOLD_C) begin
               w_state_nx   = cls_to_state(w_cand_nx);
               w_count_nx   = '0;
               w_changed_nx = 1'b1;
            end
         end
      end
   end

   // State, filter and output registers; outputs decode the next state so they align with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cand    <= CLS_EQ;
         r_count   <= '0;
         r_g       <= 1'b0;
         r_eq      <= 1'b0;
         r_l       <= 1'b0;
         r_changed <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cand    <= w_cand_nx;
         r_count   <= w_count_nx;
         r_g       <= (w_state_nx == S_GT);
         r_eq      <= (w_state_nx == S_EQ);
         r_l       <= (w_state_nx == S_LT);
         r_changed <= w_changed_nx;
      end
   end

   assign G       = r_g;
   assign Eq      = r_eq;
   assign L       = r_l;
   assign changed = r_changed;

`ifdef HYST_CMP_DIFF_EN
   // Raw difference of every accepted sample, independent of the persistence filter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_diff <= '0;
      end else if (enable && valid) begin
         r_diff <= w_diff;
      end
   end

   assign diff = r_diff;
`endif

endmodule

// File: tb/tb_hyst_comparator.sv
// tb/tb_hyst_comparator.sv - directed and randomized bench for hyst_comparator against a history-window model
module tb_hyst_comparator;

   localparam int WIDTH = 8;
   localparam int BAND  = 2;
   localparam int HOLD  = 4;

   localparam int M_NONE = 0;
   localparam int M_EQ   = 1;
   localparam int M_GT   = 2;
   localparam int M_LT   = 3;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             G;
   logic             Eq;
   logic             L;
   logic             changed;
`ifdef HYST_CMP_DIFF_EN
   logic [WIDTH-1:0] diff;
`endif

   int n_checks;
   int n_errors;

   int m_dec;
   int m_hist[$];
   int m_changed;
   int m_diff;

   hyst_comparator #(
      .WIDTH (WIDTH),
      .BAND  (BAND),
      .HOLD  (HOLD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .valid   (valid),
      .a       (a),
      .b       (b),
      .G       (G),
      .Eq      (Eq),
      .L       (L),
      .changed (changed)
`ifdef HYST_CMP_DIFF_EN
      ,
      .diff    (diff)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int cls_of(input int av, input int bv);
      int d;
      d = (av > bv) ? av - bv : bv - av;
      if (d <= BAND) return M_EQ;
      if (av > bv) return M_GT;
      return M_LT;
   endfunction

   task automatic model_reset();
      m_dec     = M_NONE;
      m_hist    = {};
      m_changed = 0;
      m_diff    = 0;
   endtask

   // Decision changes when the last HOLD accepted samples all agree on a different class
   task automatic model_step(input int en, input int v, input int av, input int bv);
      int  c;
      bit  all_same;
      m_changed = 0;
      if (en == 0) begin
         m_changed = (m_dec != M_NONE);
         m_dec     = M_NONE;
         m_hist    = {};
      end else if (v != 0) begin
         c      = cls_of(av, bv);
         m_diff = (av > bv) ? av - bv : bv - av;
         if (m_dec == M_NONE) begin
            m_dec     = c;
            m_changed = 1;
            m_hist    = {};
         end else begin
            m_hist.push_back(c);
            if (m_hist.size() > HOLD) void'(m_hist.pop_front());
            if (c != m_dec && m_hist.size() == HOLD) begin
               all_same = 1'b1;
               foreach (m_hist[i]) if (m_hist[i] != c) all_same = 1'b0;
               if (all_same) begin
                  m_dec     = c;
                  m_changed = 1;
                  m_hist    = {};
               end
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".G"}, G, (m_dec == M_GT));
      check({tag, ".Eq"}, Eq, (m_dec == M_EQ));
      check({tag, ".L"}, L, (m_dec == M_LT));
      check({tag, ".changed"}, changed, m_changed);
`ifdef HYST_CMP_DIFF_EN
      check({tag, ".diff"}, diff, m_diff);
`endif
   endtask

   task automatic step(input string tag, input int en, input int v, input int av, input int bv);
      enable = en[0];
      valid  = v[0];
      a      = av[WIDTH-1:0];
      b      = bv[WIDTH-1:0];
      @(posedge clk);
      #1;
      model_step(en, v, av, bv);
      check_outputs(tag);
   endtask

   task automatic repeat_step(input string tag, input int n, input int av, input int bv);
      for (int i = 0; i < n; i++) step(tag, 1, 1, av, bv);
   endtask

   // Same samples separated by ignored valid=0 cycles carrying junk operands
   task automatic gapped_step(input string tag, input int n, input int av, input int bv);
      for (int i = 0; i < n; i++) begin
         step(tag, 1, 0, $urandom_range(0, 255), $urandom_range(0, 255));
         step(tag, 1, 1, av, bv);
      end
   endtask

   initial begin
      int av;
      int bv;
      int dv;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      enable   = 1'b0;
      valid    = 1'b0;
      a        = '0;
      b        = '0;
      model_reset();
      #12;
      check_outputs("reset");
      reset = 1'b0;

      step("t1", 1, 1, 50, 50);
      check("t1.Eq_const", Eq, 1);
      check("t1.changed_const", changed, 1);
      step("t1b", 1, 0, 50, 50);
      check("t1b.changed_const", changed, 0);

      repeat_step("t2_band", 10, 52, 50);
      check("t2.Eq_const", Eq, 1);
      repeat_step("t2_up", 3, 53, 50);
      check("t2.G_pre", G, 0);
      step("t2_up4", 1, 1, 53, 50);
      check("t2.G_const", G, 1);
      check("t2.changed_const", changed, 1);

      repeat_step("t3_lo", 3, 40, 50);
      step("t3_hi", 1, 1, 60, 50);
      repeat_step("t3_lo2", 3, 40, 50);
      check("t3.G_hold", G, 1);
      step("t3_lo4", 1, 1, 40, 50);
      check("t3.L_const", L, 1);

      repeat_step("t3g_up", 4, 60, 50);
      check("t3g.G_const", G, 1);
      gapped_step("t3g_lo", 3, 40, 50);
      gapped_step("t3g_hi", 1, 60, 50);
      gapped_step("t3g_lo2", 3, 40, 50);
      check("t3g.G_hold", G, 1);
      gapped_step("t3g_lo4", 1, 40, 50);
      check("t3g.L_const", L, 1);

      repeat_step("t4_max", 4, 255, 0);
      check("t4.G_const", G, 1);
      repeat_step("t4_min", 4, 0, 255);
      check("t4.L_const", L, 1);
      repeat_step("t4_near", 4, 255, 254);
      check("t4.Eq_const", Eq, 1);

      repeat_step("t5_lo", 4, 10, 40);
      check("t5.L_pre", L, 1);
      step("t5_dis", 0, 1, 10, 40);
      check("t5.L_off", L, 0);
      check("t5.changed_const", changed, 1);
      step("t5_en", 1, 1, 10, 40);
      check("t5.L_const", L, 1);

      repeat_step("t6_g", 4, 200, 50);
      repeat_step("t6_cnt", 3, 20, 50);
      reset = 1'b1;
      #2;
      model_reset();
      check_outputs("t6_async");
      reset = 1'b0;
      step("t6_after", 1, 1, 70, 50);
      check("t6.G_const", G, 1);
`ifdef HYST_CMP_DIFF_EN
      check("t6.diff_const", diff, 20);
`endif

      for (int i = 0; i < 3000; i++) begin
         bv = $urandom_range(0, 255);
         if ((i % 8) == 7) begin
            av = $urandom_range(0, 255);
         end else begin
            dv = $urandom_range(0, 12);
            av = bv + dv - 6;
            if (av < 0) av = 0;
            if (av > 255) av = 255;
         end
         step("rand", ($urandom_range(0, 99) < 97) ? 1 : 0,
              ($urandom_range(0, 99) < 80) ? 1 : 0, av, bv);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
